cpu_mmu_ppn_wr: RTL
===================

// Module: cpu_mmu_ppn_wr
// PURPOSE
//  IDB-to-PPN write path of the MMU. It is the counterpart of the PPN-to-IDB read buffers.
//  - Stages a 16-bit physical page number (PPN bits 25..10) from the internal data bus (IDB) using byte-load strobes.
//  - Runs a timed write cycle that drives the staged PPN onto the page-table PPN bus with a write strobe.
//  - Reports busy, done and overrun status back to the microcode control.
// PARAMETERS
//  SETUP_CYCLES  1  cycles the PPN bus is driven before PT_WE_n falls (>=1)
//  WE_CYCLES     2  cycles PT_WE_n is held low (>=1)
//  HOLD_CYCLES   1  cycles the PPN bus is still driven after PT_WE_n rises (>=1)
// PORTS
//  sysclk         in   1   system clock; all state changes on its rising edge
//  sys_rst_n      in   1   asynchronous active-low reset
//  IDB_15_0_IN    in   16  internal data bus
//  LDL_n          in   1   load staging bits 7:0 from IDB[7:0]
//  LDU_n          in   1   load staging bits 15:8 from IDB[15:8]
//  LDUR_n         in   1   restricted upper load: staging[15:8] = {7'b0, IDB[8]}
//  WSTART_n       in   1   request a page-table write of the staged PPN (sampled per cycle)
//  PPN_25_10_OUT  out  16  PPN bus data (valid while PPN_OE_n=0)
//  PPN_OE_n       out  1   PPN bus drive enable, active low
//  PT_WE_n        out  1   page-table write strobe, active low
//  BUSY           out  1   write cycle in progress
//  DONE           out  1   one-cycle pulse after the hold phase completes
//  OVR            out  1   sticky: a load or start arrived while BUSY
//  PPN_PAR        out  1   odd parity of PPN_25_10_OUT (PPN_WR_PARITY_EN only)
// BEHAVIOUR
//  Reset (async): staging=0, PPN_25_10_OUT=0, PPN_OE_n=1, PT_WE_n=1, BUSY=0, DONE=0, OVR=0, state IDLE.
//  Reset mid-cycle: PT_WE_n and PPN_OE_n go high immediately, without waiting for a clock edge.
//  Staging loads are accepted only in IDLE. Each active strobe updates its byte at the clock edge.
//  - LDL_n and LDU_n together load the full word.
//  - LDUR_n overrides LDU_n when both are low.
//  Output register: PPN_25_10_OUT captures the staging next-value on the edge that accepts WSTART_n.
//  - A load and a start in the same cycle therefore write the newly loaded value.
//  - PPN_25_10_OUT holds its value after the cycle completes.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. A per-state counter sizes each phase by the parameters.
//   IDLE:   BUSY=0, OE_n=1, WE_n=1. WSTART_n=0 -> SETUP, BUSY=1.
//   SETUP:  OE_n=0, WE_n=1 for SETUP_CYCLES, then -> STROBE.
//   STROBE: OE_n=0, WE_n=0 for WE_CYCLES, then -> HOLD.
//   HOLD:   OE_n=0, WE_n=1 for HOLD_CYCLES, then -> IDLE.
//    DONE=1 for the first IDLE cycle after HOLD. BUSY=0 in that same cycle.
//  Latency: WSTART edge to DONE = SETUP_CYCLES+WE_CYCLES+HOLD_CYCLES+1 cycles (defaults: 5).
//  Back-to-back: WSTART_n=0 in the DONE cycle is accepted, and the next cycle enters SETUP.
//  While BUSY:
//  - WSTART_n=0 or any load strobe low is ignored.
//  - Staging and the output register do not change.
//  - OVR is set.
//  OVR clears only at reset or when a start is accepted in IDLE.
//  WSTART_n held low after acceptance does not retrigger until the FSM returns to IDLE.
//  - Held through to IDLE, it starts a new cycle.
// CONFIGURATION
//  PPN_WR_PARITY_EN defined:
//  - PPN_PAR = ~^PPN_25_10_OUT, registered alongside the data.
//  - PPN_PAR resets to 1, the odd parity of zero.
//  PPN_WR_PARITY_EN undefined: the PPN_PAR port exists and is tied to 0. No parity logic is built.
// TESTING
//  1. Reset value check.
//     - Stimulus: hold sys_rst_n=0, then release it.
//     - Required: all outputs at their reset values, PPN_PAR=1 with the macro defined.
//  2. Full-word write with defaults.
//     - Stimulus: LDL_n=LDU_n=0 with IDB=16'hA5C3; next cycle WSTART_n=0.
//     - Required: OE_n low for 4 cycles and WE_n low for cycles 2-3 of them.
//     - Required: PPN_OUT=16'hA5C3, DONE pulse 5 cycles after start.
//  3. Restricted upper load.
//     - Stimulus: LDU_n=LDUR_n=LDL_n=0 with IDB=16'hFF7E, then start.
//     - Required: PPN_OUT=16'h017E.
//  4. Busy rejection.
//     - Stimulus: during STROBE, LDL_n=0 with IDB=16'h0011, and WSTART_n=0.
//     - Required: PPN_OUT unchanged, OVR=1, single DONE. The next accepted start clears OVR.
//  5. Reset mid-operation.
//     - Stimulus: assert sys_rst_n=0 while PT_WE_n=0.
//     - Required: PT_WE_n=1 and PPN_OE_n=1 before the next sysclk edge; state IDLE.
//  6. Same-cycle load plus start, then back-to-back.
//     - Stimulus: IDB=16'h1234 with LDL_n=LDU_n=WSTART_n=0; WSTART_n=0 again in the DONE cycle.
//     - Required: the first write carries 16'h1234, and the second SETUP begins the cycle after DONE.

Source files
------------

// File: rtl/cpu_mmu_ppn_wr.sv
// IDB-to-PPN write path: byte-staged PPN plus a timed page-table write cycle.
// Optional odd parity on the PPN bus is built when PPN_WR_PARITY_EN is defined.
module cpu_mmu_ppn_wr #(
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic [15:0] IDB_15_0_IN,
  input  logic        LDL_n,
  input  logic        LDU_n,
  input  logic        LDUR_n,
  input  logic        WSTART_n,
  output logic [15:0] PPN_25_10_OUT,
  output logic        PPN_OE_n,
  output logic        PT_WE_n,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVR,
  output logic        PPN_PAR
);

  localparam int MAX_A = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] WE_LAST    = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   stage_r;
  logic [15:0]   stage_next_s;
  logic [15:0]   ppn_r;
  logic          oe_n_r;
  logic          we_n_r;
  logic          busy_r;
  logic          done_r;
  logic          ovr_r;
  logic          start_s;
  logic          busy_hit_s;

  function automatic logic odd_parity(input logic [15:0] d);
    return ~^d;
  endfunction

  // Staging next-value: restricted upper load wins over the plain upper load
  always_comb begin
    stage_next_s = stage_r;
    if (!LDL_n) begin
      stage_next_s[7:0] = IDB_15_0_IN[7:0];
    end else begin
      stage_next_s[7:0] = stage_r[7:0];
    end
    if (!LDUR_n) begin
      stage_next_s[15:8] = {7'b0000000, IDB_15_0_IN[8]};
    end else if (!LDU_n) begin
      stage_next_s[15:8] = IDB_15_0_IN[15:8];
    end else begin
      stage_next_s[15:8] = stage_r[15:8];
    end
  end

  assign start_s    = (state_r == IDLE) && !WSTART_n;
  assign busy_hit_s = (state_r != IDLE) && (!WSTART_n || !LDL_n || !LDU_n || !LDUR_n);

  // Write-cycle FSM with registered bus controls, status and output data
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      stage_r <= 16'h0000;
      ppn_r   <= 16'h0000;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (busy_hit_s) begin
        ovr_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          stage_r <= stage_next_s;
          done_r  <= 1'b0;
          if (start_s) begin
            state_r <= SETUP;
            cnt_r   <= '0;
            ppn_r   <= stage_next_s;
            oe_n_r  <= 1'b0;
            we_n_r  <= 1'b1;
            busy_r  <= 1'b1;
            ovr_r   <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt_r == SETUP_LAST) begin
            state_r <= STROBE;
            cnt_r   <= '0;
            we_n_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        STROBE: begin
          if (cnt_r == WE_LAST) begin
            state_r <= HOLD;
            cnt_r   <= '0;
            we_n_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            oe_n_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          oe_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PPN_WR_PARITY_EN
  logic par_r;

  // Parity register tracks the output data register
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      par_r <= 1'b1;
    end else if (start_s) begin
      par_r <= odd_parity(stage_next_s);
    end else begin
      par_r <= par_r;
    end
  end

  assign PPN_PAR = par_r;
`else
  assign PPN_PAR = 1'b0;
`endif

  assign PPN_25_10_OUT = ppn_r;
  assign PPN_OE_n      = oe_n_r;
  assign PT_WE_n       = we_n_r;
  assign BUSY          = busy_r;
  assign DONE          = done_r;
  assign OVR           = ovr_r;

endmodule
